sel_route_unit: RTL and testbench
=================================

Name: sel_route_unit

Overview:
- Registered selection/routing primitive block used by the register-file and memory address-decode paths.
- Bundles three independent functions, each with its own registered output:
  - 1-bit 2:1 mux.
  - 1-to-8 demultiplexer (load-enable decode).
  - 8-way WIDTH-bit word mux (read-data select).
- Each function samples its inputs on the rising clk edge and presents its result one cycle later.

Parameters:
- WIDTH, 16, bit width of each 8-way mux data input and of m8_out.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- mux_sel  input  1  2:1 mux select.
- mux_a  input  1  2:1 mux input, selected when mux_sel=0.
- mux_b  input  1  2:1 mux input, selected when mux_sel=1.
- mux_out  output  1  registered 2:1 mux result.
- dmux_in  input  1  demux data/enable input.
- dmux_sel  input  3  demux destination index 0..7.
- dmux_out  output  8  registered demux outputs; bit i is destination i.
- m8_sel  input  3  word-mux select 0..7.
- m8_in0 .. m8_in7  input  WIDTH each  word-mux data inputs; eight separate ports.
- m8_out  output  WIDTH  registered word-mux result.

Behaviour:
- Reset:
  - Sampled only on the rising clk edge.
  - When rst_n=0 at an edge: mux_out=0, dmux_out=8'h00, m8_out=0, regardless of all other inputs.
  - Reset dominates any simultaneous input change.
  - Asserting rst_n mid-operation clears all outputs at that edge.
  - First valid result appears at the edge after the first edge with rst_n=1.
- Latency: exactly 1 cycle for all three functions.
  - Outputs are direct flop outputs.
  - No combinational path from any input to any output.
  - Inputs sampled at edge N appear at outputs after edge N.
- 2:1 mux:
  - mux_out <= mux_sel ? mux_b : mux_a.
- Demux:
  - For i in 0..7: dmux_out[i] <= (dmux_sel==i) ? dmux_in : 0.
  - Consequences: at most one bit set; dmux_in=0 gives 8'h00; dmux_in=1 gives one-hot (1 << dmux_sel).
- Word mux:
  - m8_out <= m8_in[m8_sel] across all WIDTH bits, with m8_sel interpreted as an unsigned index.
  - Select mapping: 3'b000 selects m8_in0 … 3'b111 selects m8_in7.
- Independence:
  - The three functions share only clk and rst_n.
  - Changing one function's inputs never affects another function's output.
- Boundaries:
  - All 8 select codes are valid; there are no illegal or X states after reset.
  - WIDTH must be >= 1.
  - No handshake, no enable, no hold. Every non-reset edge reloads all outputs from their current inputs.
- Structure:
  - Implement the selection logic from gate-level style and/not/or (or equivalent continuous assignments) feeding the output flops.
  - Behavioural case statements inside the clocked block are also acceptable.
  - No latches.

Test Plan:
- Reset: drive all inputs to ones, rst_n=0 for 2 edges -> mux_out=0, dmux_out=8'h00, m8_out=16'h0000. Release rst_n -> next edge shows mux_out=1, dmux_out=8'h80 (dmux_sel=7), m8_out=m8_in7.
- 2:1 mux exhaustive: all 8 combos of (mux_sel,mux_a,mux_b) -> mux_out one cycle later. Example: sel=0,a=1,b=0 -> 1; sel=1,a=1,b=0 -> 0.
- Demux sweep: dmux_in=1, dmux_sel=0..7 -> dmux_out = 8'h01, 02, 04, 08, 10, 20, 40, 80 on successive cycles. Repeat with dmux_in=0 -> 8'h00 for every sel.
- Word mux sweep: m8_in_k = 16'h1111*k, with m8_in0=16'hA5A5. Sweep m8_sel 0..7 -> m8_out = A5A5, 1111, 2222, … 7777, each one cycle after its select. Changing a non-selected input leaves m8_out unchanged.
- Latency/independence: toggle mux_sel every cycle while dmux_sel and m8_sel are held. Check mux_out lags mux_sel by exactly one cycle and dmux_out/m8_out stay constant.
- Mid-run reset: during the word-mux sweep at m8_sel=5, drop rst_n for one edge -> all outputs zero that cycle. The next edge resumes with m8_out=m8_in for the then-current sel.

Source files
------------

// File: rtl/sel_route_unit.sv
// Registered select/route primitives: 1-bit 2:1 mux, 1-to-8 demux, 8-way word mux.
// Each result is a flop output, one cycle after its inputs are sampled.
module sel_route_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mux_sel,
    input  logic             mux_a,
    input  logic             mux_b,
    output logic             mux_out,
    input  logic             dmux_in,
    input  logic [2:0]       dmux_sel,
    output logic [7:0]       dmux_out,
    input  logic [2:0]       m8_sel,
    input  logic [WIDTH-1:0] m8_in0,
    input  logic [WIDTH-1:0] m8_in1,
    input  logic [WIDTH-1:0] m8_in2,
    input  logic [WIDTH-1:0] m8_in3,
    input  logic [WIDTH-1:0] m8_in4,
    input  logic [WIDTH-1:0] m8_in5,
    input  logic [WIDTH-1:0] m8_in6,
    input  logic [WIDTH-1:0] m8_in7,
    output logic [WIDTH-1:0] m8_out
);

    logic             mux_d, mux_q;
    logic [7:0]       dmux_d, dmux_q;
    logic [WIDTH-1:0] m8_d, m8_q;
    logic [WIDTH-1:0] words [8];

    assign mux_d = (mux_sel & mux_b) | (~mux_sel & mux_a);

    for (genvar i = 0; i < 8; i++) begin : g_dmux
        assign dmux_d[i] = dmux_in & (dmux_sel == 3'(i));
    end

    assign words[0] = m8_in0;
    assign words[1] = m8_in1;
    assign words[2] = m8_in2;
    assign words[3] = m8_in3;
    assign words[4] = m8_in4;
    assign words[5] = m8_in5;
    assign words[6] = m8_in6;
    assign words[7] = m8_in7;

    // AND-OR word select: exactly one decoded term is ever enabled
    always_comb begin
        m8_d = '0;
        for (int i = 0; i < 8; i++) begin
            m8_d = m8_d | ({WIDTH{m8_sel == 3'(i)}} & words[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_q  <= 1'b0;
            dmux_q <= 8'h00;
            m8_q   <= '0;
        end else begin
            mux_q  <= mux_d;
            dmux_q <= dmux_d;
            m8_q   <= m8_d;
        end
    end

    assign mux_out  = mux_q;
    assign dmux_out = dmux_q;
    assign m8_out   = m8_q;

endmodule

// File: tb/tb_sel_route_unit.sv
// Directed bench for sel_route_unit with an expected-result queue.
// Expectations are pushed at drive time and popped one edge later.
module tb_sel_route_unit;

    typedef struct packed {
        logic        mux;
        logic [7:0]  dm;
        logic [15:0] m8;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mux_sel, mux_a, mux_b, mux_out;
    logic        dmux_in;
    logic [2:0]  dmux_sel;
    logic [7:0]  dmux_out;
    logic [2:0]  m8_sel;
    logic [15:0] w [8];
    logic [15:0] m8_out;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sel_route_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mux_sel(mux_sel), .mux_a(mux_a), .mux_b(mux_b), .mux_out(mux_out),
        .dmux_in(dmux_in), .dmux_sel(dmux_sel), .dmux_out(dmux_out),
        .m8_sel(m8_sel),
        .m8_in0(w[0]), .m8_in1(w[1]), .m8_in2(w[2]), .m8_in3(w[3]),
        .m8_in4(w[4]), .m8_in5(w[5]), .m8_in6(w[6]), .m8_in7(w[7]),
        .m8_out(m8_out)
    );

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] x);
        compared++;
        assert (o === x) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    // Inputs are driven away from posedge; expectation captured at drive time
    task automatic step(input string tag);
        exp_t e;
        e.mux = !rst_n ? 1'b0 : (mux_sel ? mux_b : mux_a);
        e.dm  = (!rst_n || !dmux_in) ? 8'h00 : (8'h01 << dmux_sel);
        e.m8  = !rst_n ? 16'h0000 : w[m8_sel];
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".mux"}, 32'(mux_out), 32'(e.mux));
        chk({tag, ".dmux"}, 32'(dmux_out), 32'(e.dm));
        chk({tag, ".m8"}, 32'(m8_out), 32'(e.m8));
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        mux_sel = 1'b1; mux_a = 1'b1; mux_b = 1'b1;
        dmux_in = 1'b1; dmux_sel = 3'd7;
        m8_sel = 3'd7;
        for (int i = 0; i < 8; i++) w[i] = 16'hFFFF;
        step("reset0");
        step("reset1");
        rst_n = 1'b1;
        step("release");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            c = 3'(i);
            {mux_sel, mux_a, mux_b} = c;
            step("mux2");
        end

        for (int v = 1; v >= 0; v--) begin
            dmux_in = 1'(v);
            for (int s = 0; s < 8; s++) begin
                dmux_sel = 3'(s);
                step("demux");
            end
        end

        w[0] = 16'hA5A5;
        for (int k = 1; k < 8; k++) w[k] = 16'(16'h1111 * k);
        for (int s = 0; s < 8; s++) begin
            m8_sel = 3'(s);
            rst_n = (s != 5);
            step(s == 5 ? "midreset" : "m8sweep");
        end
        rst_n = 1'b1;
        m8_sel = 3'd5;
        step("resume");

        m8_sel = 3'd3;
        w[6] = 16'hDEAD;
        w[0] = 16'hBEEF;
        step("nonsel");

        dmux_in = 1'b1; dmux_sel = 3'd2;
        mux_a = 1'b0; mux_b = 1'b1;
        for (int t = 0; t < 6; t++) begin
            mux_sel = 1'(t);
            step("latency");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
